// File: rtl/sdf_stage_ctrl.sv
// Counted enable/twiddle sequencer for one radix-2 SDF FFT stage.
// Define SDF_CTRL_TF_EN to generate twiddle addresses; otherwise tf_addr is tied to 0.
module sdf_stage_ctrl #(
  parameter int float_len   = 32,
  parameter int depth_log2  = 1,
  parameter int tf_addr_len = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_in_valid,
  input  logic                   flush,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   in_ready,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  output logic                   bf_en,
  output logic                   wr_sel,
  output logic [tf_addr_len-1:0] tf_addr,
  output logic                   out_valid,
  output logic                   out_sel,
  output logic                   frame_done,
  output logic                   err
);

  if (tf_addr_len < 1 || tf_addr_len > depth_log2 || float_len < 1) begin : g_param_check
    $error("sdf_stage_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PAIR, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [depth_log2-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  pending_q, pending_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sel_q, out_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  wrap;

  assign cnt_inc = cnt_q + depth_log2'(1);
  assign wrap    = (cnt_inc == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_sel_q    <= out_sel_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Enables are gated by rst so the combinational outputs read as idle during reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    in_ready     = (state_q != ST_DRAIN);
    fifo_wr_en   = 1'b0;
    fifo_rd_en   = 1'b0;
    bf_en        = 1'b0;
    wr_sel       = 1'b0;
    accept       = data_in_valid && in_ready && !rst;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          fifo_wr_en = 1'b1;
          fifo_rd_en = pending_q;
          cnt_d      = cnt_inc;
          if (wrap) begin
            pending_d = 1'b0;
            state_d   = ST_PAIR;
          end else begin
            state_d   = ST_FILL;
          end
        end else if (flush && !rst && cnt_q == '0) begin
          state_d = pending_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_PAIR: begin
        if (accept) begin
          fifo_rd_en = 1'b1;
          fifo_wr_en = 1'b1;
          wr_sel     = 1'b1;
          bf_en      = 1'b1;
          cnt_d      = cnt_inc;
          if (wrap) begin
            pending_d    = 1'b1;
            frame_done_d = 1'b1;
            state_d      = ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (!rst) begin
          fifo_rd_en = 1'b1;
          cnt_d      = cnt_inc;
          if (wrap) begin
            pending_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase

    out_valid_d = bf_en || fifo_rd_en;
    out_sel_d   = fifo_rd_en && !bf_en;
    err_d       = err_q
                | (fifo_wr_en && fifo_full)
                | (fifo_rd_en && fifo_empty)
                | (state_q == ST_DRAIN && data_in_valid);
  end

`ifdef SDF_CTRL_TF_EN
  // Top bits of the pair index give the twiddle exponent for this stage.
  assign tf_addr = (state_q == ST_PAIR) ? cnt_q[depth_log2-1 -: tf_addr_len] : '0;
`else
  assign tf_addr = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_sel    = out_sel_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Scoreboard bench for sdf_stage_ctrl; reference model works on accepted-sample index arithmetic.
module tb_sdf_stage_ctrl;

  localparam int DL2 = 2;
  localparam int TAL = 1;
  localparam int D   = 1 << DL2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           data_in_valid = 1'b0;
  logic           flush = 1'b0;
  logic           fifo_full = 1'b0;
  logic           fifo_empty = 1'b0;
  logic           in_ready, fifo_wr_en, fifo_rd_en, bf_en, wr_sel;
  logic [TAL-1:0] tf_addr;
  logic           out_valid, out_sel, frame_done, err;

  sdf_stage_ctrl #(.float_len(32), .depth_log2(DL2), .tf_addr_len(TAL)) dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .flush(flush),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .in_ready(in_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .bf_en(bf_en), .wr_sel(wr_sel),
    .tf_addr(tf_addr), .out_valid(out_valid), .out_sel(out_sel),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic sel;} exp_t;
  exp_t sb_q[$];
  int   fd_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model: position of next sample within the 2*D block
  int   pos = 0;
  bit   pending_m = 0;
  bit   draining_m = 0;
  int   drain_n = 0;
  bit   err_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      bit exp_v, exp_fd;
      exp_t e;
      @(posedge clk);
      cyc++;
      #2;
      exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      chk("out_valid", int'(out_valid), int'(exp_v));
      if (exp_v) begin
        e = sb_q.pop_front();
        chk("out_sel", int'(out_sel), int'(e.sel));
      end
      exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
      if (exp_fd) void'(fd_q.pop_front());
      if (frame_done || exp_fd) chk("frame_done", int'(frame_done), int'(exp_fd));
    end
  end

  task automatic step(input bit v, input bit fl, input bit ff, input bit fe);
    bit e_rdy, e_wr, e_rd, e_bf, e_sel, err_ev;
    int e_tf;
    @(negedge clk);
    data_in_valid = v; flush = fl; fifo_full = ff; fifo_empty = fe;
    #1;
    e_rdy = 1; e_wr = 0; e_rd = 0; e_bf = 0; e_sel = 0; e_tf = 0; err_ev = 0;
    if (draining_m) begin
      e_rdy = 0; e_rd = 1; err_ev = v;
      sb_q.push_back('{cyc + 1, 1'b1});
      drain_n++;
      if (drain_n == D) begin draining_m = 0; pending_m = 0; end
    end else if (v) begin
      e_wr = 1;
      if (pos >= D) begin
        e_rd = 1; e_bf = 1; e_sel = 1;
        e_tf = (pos - D) >> (DL2 - TAL);
        sb_q.push_back('{cyc + 1, 1'b0});
      end else begin
        e_rd = pending_m;
        if (pending_m) sb_q.push_back('{cyc + 1, 1'b1});
      end
      pos++;
      if (pos == D) pending_m = 0;
      if (pos == 2 * D) begin
        pos = 0; pending_m = 1;
        fd_q.push_back(cyc + 1);
      end
    end else if (fl && pos == 0 && pending_m) begin
      draining_m = 1; drain_n = 0;
    end
    err_ev = err_ev | (e_wr && ff) | (e_rd && fe);
    chk("in_ready", int'(in_ready), int'(e_rdy));
    chk("fifo_wr_en", int'(fifo_wr_en), int'(e_wr));
    chk("fifo_rd_en", int'(fifo_rd_en), int'(e_rd));
    chk("bf_en", int'(bf_en), int'(e_bf));
    if (e_wr) chk("wr_sel", int'(wr_sel), int'(e_sel));
`ifdef SDF_CTRL_TF_EN
    if (e_bf) chk("tf_addr", int'(tf_addr), e_tf);
`else
    if (e_bf) chk("tf_addr", int'(tf_addr), 0);
`endif
    err_m = err_m | err_ev;
    @(posedge clk);
    #1;
    chk("err", int'(err), int'(err_m));
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst = 1'b1; data_in_valid = v; flush = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_bf_en", int'(bf_en), 0);
    chk("rst_tf_addr", int'(tf_addr), 0);
    sb_q.delete(); fd_q.delete();
    pos = 0; pending_m = 0; draining_m = 0; drain_n = 0; err_m = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; data_in_valid = 1'b0;
  endtask

  initial begin
    do_reset(1'b1);
    // continuous stream: fill, pair, then fill with pending differences
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);

    // one block then flush to drain; a valid during drain flags err
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // gapped stream must follow valid exactly
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    // reset in the middle of a block, then restart
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);

    // FIFO flag protocol errors stay sticky until reset
    do_reset(1'b0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // randomized traffic with occasional flush
    do_reset(1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 0);
    for (int i = 0; i < 2 * D + 2; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    chk("fd_drained", fd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage. It drives the write/read enables of the stage's 2^depth_log2-entry delay FIFO and the butterfly enable, generates the twiddle ROM address, and tags each output sample as a butterfly sum or a fed-back difference. One instance sits beside every FFT stage and replaces the edge-triggered full/empty enable logic with a counted, fully synchronous schedule.

## Interface
- float_len, 32, width of one real/imag float; the datapath carries float_len*2 bits (control only, no data ports here)
- depth_log2, 1, log2 of the FIFO depth DEPTH (stage 1 of an 8192-point FFT uses 12)
- tf_addr_len, 1, twiddle ROM address width; must satisfy tf_addr_len <= depth_log2

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_in_valid  in  1  input sample present this cycle
- flush  in  1  request to drain pending differences with no further input
- fifo_full  in  1  FIFO full flag (checking only)
- fifo_empty  in  1  FIFO empty flag (checking only)
- in_ready  out  1  stage accepts input; combinational, 0 only in DRAIN
- fifo_wr_en  out  1  FIFO write, combinational
- fifo_rd_en  out  1  FIFO read, combinational
- bf_en  out  1  butterfly computes x1 = FIFO head, x2 = current input; combinational
- wr_sel  out  1  FIFO write source: 0 = raw input, 1 = butterfly difference x1-x2; combinational
- tf_addr  out  tf_addr_len  twiddle address, valid while bf_en
- out_valid  out  1  stage output valid, registered
- out_sel  out  1  output source, registered: 0 = butterfly sum, 1 = FIFO difference
- frame_done  out  1  one-cycle pulse after last pair of a block, registered
- err  out  1  sticky protocol error, registered

## Operation
- State: IDLE, FILL, PAIR, DRAIN; counter cnt (depth_log2 bits); pending flag (FIFO holds DEPTH differences).
- An accepted sample is data_in_valid && in_ready.
- IDLE: accepted sample -> wr_en=1, wr_sel=0, cnt=1, go FILL (if DEPTH==2 with cnt wrap, go PAIR when cnt reaches 0 per rule below).
- FILL: each accepted sample -> wr_en=1, wr_sel=0, rd_en=pending; cnt++. When cnt wraps to 0: pending<=0, go PAIR.
- PAIR: each accepted sample -> rd_en=1, wr_en=1, wr_sel=1, bf_en=1; cnt++. On wrap: pending<=1, frame_done pulse, go FILL.
- FILL/IDLE with cnt==0 and flush=1: if pending go DRAIN else stay/go IDLE. flush at any other point is ignored.
- DRAIN: rd_en=1 every cycle, no write, cnt++; on wrap pending<=0, go IDLE. data_in_valid here is dropped and sets err.
- tf_addr = cnt[depth_log2-1 : depth_log2-tf_addr_len] in PAIR, 0 otherwise.
- err sets when (wr_en && fifo_full) or (rd_en && fifo_empty) or input dropped in DRAIN; cleared only by rst.
- Gaps in data_in_valid stall cnt and all enables; state holds.

## Timing
- Enables, bf_en, wr_sel, tf_addr: zero latency (same cycle as accepted sample).
- out_valid/out_sel: 1 cycle after the corresponding read/butterfly cycle (FIFO and butterfly register once). out_valid = registered (bf_en || rd_en); out_sel = registered (rd_en && !bf_en).
- Reset values: state IDLE, cnt 0, pending 0, out_valid 0, out_sel 0, frame_done 0, err 0; combinational outputs 0 except in_ready=1.
- Reset mid-block abandons the block; FIFO shares rst so it is empty on release.
- Steady stream: one output per input with fixed DEPTH-sample block offset, no bubbles.

## Configuration
- SDF_CTRL_TF_EN defined: tf_addr generated as above.
- Not defined: tf_addr tied to 0 (stage uses trivial twiddle W^0, e.g. final stage); all other behaviour identical.

## Test plan
- depth_log2=2, 8 continuous valids -> wr_en on all 8, bf_en on samples 5-8, tf_addr 0,0,1,1 (tf_addr_len=1), frame_done 1 cycle after sample 8.
- 12 continuous valids -> samples 9-12: rd_en=1, wr_sel=0; out_sel=1 on their outputs; out_valid count = 8 from cycle after sample 5.
- 8 valids then flush at cnt==0 -> DRAIN 4 cycles with rd_en=1, in_ready=0, then IDLE; valid during DRAIN -> err=1.
- Valid toggling every other cycle -> enables track valid exactly, cnt stalls, same output sequence as continuous.
- rst pulsed at sample 6 -> all outputs at reset values asynchronously; next valid restarts FILL with cnt=1.
- Force fifo_full=1 during a write -> err=1 and stays until rst.
